// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot/program loader.
// Holds the loader state encoding and the per-state output flags.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned CSUM_W         = 8;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    CSUM   = 3'd5,
    RUN    = 3'd6,
    ERR    = 3'd7
  } ld_state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic err;
    logic run;
  } ld_flags_t;

  // Status outputs that belong to each state; registered together with the state.
  function automatic ld_flags_t flags_of(input ld_state_t s);
    ld_flags_t f;
    f = '0;
    case (s)
      HDR_HI, HDR_LO, DAT_HI, DAT_LO, CSUM: begin
        f.ready = 1'b1;
        f.busy  = 1'b1;
      end
      RUN: begin
        f.done = 1'b1;
        f.run  = 1'b1;
      end
      ERR:     f.err = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Loads a framed, checksummed byte stream into instruction RAM and
// releases the cpu from reset only after a valid frame (or an explicit run_req).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_resetN,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BYTE_W    = DATA_W / BYTES_PER_WORD;
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  ld_state_t         state;
  ld_flags_t         flags;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W:0]   idx;
  logic [CSUM_W-1:0] csum;
  logic [BYTE_W-1:0] hi;

  logic              accept;
  logic [CSUM_W-1:0] csum_add;
  logic [CNT_W-1:0]  cnt_rx;
  logic              last_word;

  assign accept    = byte_valid && flags.ready;
  assign csum_add  = csum + CSUM_W'(byte_data);
  assign cnt_rx    = {cnt[CNT_W-1:8], byte_data};
  assign last_word = (32'(idx) + 32'd1) == 32'(cnt);

  assign byte_ready = flags.ready;
  assign busy       = flags.busy;
  assign done       = flags.done;
  assign err        = flags.err;
  assign cpu_resetN = flags.run;

  // Loader FSM; status flags are loaded alongside every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      flags      <= flags_of(IDLE);
      cnt        <= '0;
      idx        <= '0;
      csum       <= '0;
      hi         <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= HDR_HI;
            flags <= flags_of(HDR_HI);
            csum  <= '0;
            idx   <= '0;
          end else if (run_req) begin
            state <= RUN;
            flags <= flags_of(RUN);
          end
        end
        HDR_HI: begin
          if (accept) begin
            csum  <= csum_add;
            cnt   <= CNT_W'({byte_data, 8'h00});
            state <= HDR_LO;
            flags <= flags_of(HDR_LO);
          end
        end
        HDR_LO: begin
          if (accept) begin
            csum <= csum_add;
            cnt  <= cnt_rx;
            if (32'(cnt_rx) > MAX_WORDS) begin
              state <= ERR;
              flags <= flags_of(ERR);
            end else if (cnt_rx == '0) begin
              state <= CSUM;
              flags <= flags_of(CSUM);
            end else begin
              state <= DAT_HI;
              flags <= flags_of(DAT_HI);
            end
          end
        end
        DAT_HI: begin
          if (accept) begin
            csum  <= csum_add;
            hi    <= BYTE_W'(byte_data);
            state <= DAT_LO;
            flags <= flags_of(DAT_LO);
          end
        end
        DAT_LO: begin
          if (accept) begin
            csum       <= csum_add;
            imem_we    <= 1'b1;
            imem_addr  <= idx[ADDR_W-1:0];
            imem_wdata <= DATA_W'({hi, byte_data});
            idx        <= idx + (ADDR_W+1)'(1);
            if (last_word) begin
              state <= CSUM;
              flags <= flags_of(CSUM);
            end else begin
              state <= DAT_HI;
              flags <= flags_of(DAT_HI);
            end
          end
        end
        CSUM: begin
          if (accept) begin
            csum <= csum_add;
            if (csum_add == '0) begin
              state <= RUN;
              flags <= flags_of(RUN);
            end else begin
              state <= ERR;
              flags <= flags_of(ERR);
            end
          end
        end
        RUN: begin
          if (start) begin
            state <= HDR_HI;
            flags <= flags_of(HDR_HI);
            csum  <= '0;
            idx   <= '0;
          end
        end
        ERR: begin
          if (start) begin
            state <= HDR_HI;
            flags <= flags_of(HDR_HI);
            csum  <= '0;
            idx   <= '0;
          end else if (run_req) begin
            state <= RUN;
            flags <= flags_of(RUN);
          end
        end
        default: begin
          state <= IDLE;
          flags <= flags_of(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a frame-level model predicts RAM writes
// and the loader's mode, and a per-cycle monitor compares the DUT against it.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_ERR} mode_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              run_req = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_resetN;
  logic              busy;
  logic              done;
  logic              err;

  int    n_chk = 0;
  int    n_pass = 0;
  int    we_cnt = 0;
  int    we_base;
  bit    chk_en = 1'b0;
  mode_t exp_mode = M_IDLE;
  wr_t   exp_q[$];
  wr_t   obs_q[$];
  byte_q_t f;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .run_req    (run_req),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_resetN (cpu_resetN),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    else n_pass++;
  endfunction

  // Expected {byte_ready, busy, done, err, cpu_resetN} for each loader mode.
  function automatic logic [4:0] exp_flags(input mode_t m);
    case (m)
      M_LOAD:  return 5'b11000;
      M_RUN:   return 5'b00101;
      M_ERR:   return 5'b00010;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [7:0] byte_sum(input byte_q_t q);
    logic [7:0] s;
    s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  // Model: a frame with acceptable count writes its words at 0,1,2,...
  task automatic expect_frame(input byte_q_t q);
    int unsigned n;
    wr_t w;
    n = 32'({q[0], q[1]});
    if (n <= 32768) begin
      for (int i = 0; i < int'(n); i++) begin
        if (3 + 2 * i < q.size()) begin
          w.a = ADDR_W'(i);
          w.d = {q[2 + 2 * i], q[3 + 2 * i]};
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // Per-cycle monitor, sampled 1ns after the active edge.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (chk_en) begin
      chk("status", 32'({byte_ready, busy, done, err, cpu_resetN}), 32'(exp_flags(exp_mode)));
      if (imem_we) begin
        we_cnt++;
        w.a = imem_addr;
        w.d = imem_wdata;
        obs_q.push_back(w);
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("we_addr", 32'(imem_addr), 32'(e.a));
          chk("we_data", 32'(imem_wdata), 32'(e.d));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input mode_t after);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("byte_accept_timeout", 32'd0, 32'd1);
    else exp_mode = after;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic feed(input byte_q_t q, input int max_gap, input mode_t fin);
    for (int i = 0; i < q.size(); i++)
      send_byte(q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0,
                (i == q.size() - 1) ? fin : M_LOAD);
  endtask

  task automatic load(input byte_q_t q, input int max_gap);
    int unsigned n;
    mode_t fin;
    n = 32'({q[0], q[1]});
    expect_frame(q);
    if (n > 32768) fin = M_ERR;
    else fin = (byte_sum(q) == 8'h00) ? M_RUN : M_ERR;
    feed(q, max_gap, fin);
    repeat (2) @(negedge clk);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    exp_mode = M_LOAD;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_run();
    run_req  = 1'b1;
    exp_mode = M_RUN;
    @(negedge clk);
    run_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    chk({tag, "_flags"}, 32'({byte_ready, busy, done, err, cpu_resetN}), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Normal load from IDLE.
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    we_base = we_cnt;
    load(f, 0);
    chk("norm_we_count", 32'(we_cnt - we_base), 32'd2);
    chk("norm_w0_addr", 32'(obs_q[0].a), 32'd0);
    chk("norm_w0_data", 32'(obs_q[0].d), 32'h1234);
    chk("norm_w1_addr", 32'(obs_q[1].a), 32'd1);
    chk("norm_w1_data", 32'(obs_q[1].d), 32'hABCD);
    chk("norm_run", 32'({done, cpu_resetN, err}), 32'b110);

    // Restart while running, then a bad checksum.
    pulse_start();
    chk("restart_cpu_held", 32'(cpu_resetN), 32'd0);
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    we_base = we_cnt;
    load(f, 0);
    chk("bad_we_count", 32'(we_cnt - we_base), 32'd2);
    chk("bad_err", 32'({err, cpu_resetN, byte_ready}), 32'b100);
    pulse_run();
    chk("bad_run_req", 32'({done, cpu_resetN, err}), 32'b110);

    // Empty frame.
    pulse_start();
    f = '{8'h00, 8'h00, 8'h00};
    we_base = we_cnt;
    load(f, 0);
    chk("empty_we_count", 32'(we_cnt - we_base), 32'd0);
    chk("empty_run", 32'(cpu_resetN), 32'd1);

    // Oversize count, then bytes offered while not ready.
    pulse_start();
    f = '{8'h80, 8'h01};
    load(f, 0);
    chk("over_err", 32'(err), 32'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("over_not_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;

    // Normal frame with random gaps, started from ERR.
    pulse_start();
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    we_base = we_cnt;
    load(f, 2);
    chk("gap_we_count", 32'(we_cnt - we_base), 32'd2);
    chk("gap_w1_data", 32'(obs_q[obs_q.size() - 1].d), 32'hABCD);
    chk("gap_run", 32'({done, cpu_resetN}), 32'b11);

    // Reset mid-frame after 00 02 12.
    pulse_start();
    f = '{8'h00, 8'h02, 8'h12};
    feed(f, 0, M_LOAD);
    we_base = we_cnt;
    reset    = 1'b1;
    exp_mode = M_IDLE;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset_no_we", 32'(we_cnt - we_base), 32'd0);

    // Largest legal count is accepted as a data phase.
    pulse_start();
    f = '{8'h80, 8'h00};
    feed(f, 0, M_LOAD);
    chk("max_cnt_loading", 32'({busy, err, byte_ready}), 32'b101);
    reset    = 1'b1;
    exp_mode = M_IDLE;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // start and run_req together in IDLE: start wins.
    start    = 1'b1;
    run_req  = 1'b1;
    exp_mode = M_LOAD;
    @(negedge clk);
    start   = 1'b0;
    run_req = 1'b0;
    chk("both_pulses", 32'({busy, cpu_resetN, done}), 32'b100);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
